moore_seq_detector_param: RTL and testbench
===========================================

Name: moore_seq_detector_param

Overview:
- Parametrised Moore serial pattern detector. Generalises the fixed 4-bit "1101" Moore detector to any pattern of length SEQ_LEN.
- Adds selectable overlap/non-overlap mode, an input-valid qualifier and a saturating detection counter.
- Sits on a 1-bit serial data stream. Exposes current and next state for debug and waveform inspection.

Parameters:
- SEQ_LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, SEQ_LEN-bit pattern; PATTERN[SEQ_LEN-1] is the first bit received.
- OVERLAP, 1, 1 = overlapping detection allowed; 0 = matching restarts from empty after each detection.
- CNT_W, 8, width of the detection counter.
- ST_W, $clog2(SEQ_LEN+1), state width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  seq_in sampled only when high
- seq_in  input  1  serial data bit
- seq_out  output  1  Moore detect flag; high while crnt_state == SEQ_LEN
- det_count  output  CNT_W  number of detections since reset, saturating
- crnt_state  output  ST_W  registered state = number of pattern bits currently matched
- nxt_state  output  ST_W  combinational next state

Behaviour:
- One clock domain; all registers update on rising clk. Reset is synchronous, active-high, and dominates all other inputs.
- Reset values: crnt_state = 0, seq_out = 0, det_count = 0. nxt_state = 0 while reset is high.
- State encoding: state k (0..SEQ_LEN) means the last k accepted bits equal the first k pattern bits. State SEQ_LEN is the DETECT state.
- Transition from state k < SEQ_LEN on accepted bit b:
  - If b == PATTERN[SEQ_LEN-1-k], go to k+1.
  - Otherwise go to the longest j ≤ k such that the last j bits of (matched prefix ++ b) equal the first j pattern bits (KMP fallback). The fallback table is computed at elaboration from PATTERN; no hand-coded states.
- Transition from DETECT:
  - OVERLAP = 1: treat as state L, where L is the length of the longest proper border of PATTERN, then apply the rule above.
  - OVERLAP = 0: treat as state 0, then apply the rule above.
- in_valid = 0: nxt_state = crnt_state. State, seq_out and det_count hold.
- Moore output: seq_out is a pure function of crnt_state, never of seq_in. seq_out rises the cycle after the sampling edge that captures the last pattern bit. It stays high for as long as DETECT is held, including through in_valid gaps.
- Counter: det_count increments by 1 on each edge where nxt_state == SEQ_LEN and in_valid == 1, i.e. on each entry or re-entry into DETECT.
  - DETECT -> DETECT (e.g. pattern 11 with overlap) counts each time.
  - det_count saturates at 2^CNT_W - 1 and never wraps.
- Reset mid-match: the next edge forces state 0 and clears the counter. The partial match is discarded.
- Latency: 1 cycle from the final pattern bit to seq_out = 1.

Test Plan:
- Defaults, reset held 1 cycle, then valid bits 1,1,0,1,1,0,1,0,1 one per cycle -> seq_out high exactly in the cycles after bits 4 and 7. det_count ends at 2. crnt_state after bit 5 = 2.
- OVERLAP = 0, same stream -> single pulse after bit 4; det_count = 1. State after bit 5 = 1, after bit 6 = 0.
- Defaults, stream 1,1,0 then in_valid = 0 for 3 cycles, then 1 -> state holds at 3 during the gap. Detect one cycle after the final bit; det_count = 1.
- SEQ_LEN = 3, PATTERN = 3'b010, OVERLAP = 1, stream 0,1,0,1,0 -> detections after bits 3 and 5; det_count = 2.
- CNT_W = 2, SEQ_LEN = 2, PATTERN = 2'b11, OVERLAP = 1, seven consecutive 1s -> det_count 1,2,3,3,3,3 after bits 2..7. seq_out stays high from the cycle after bit 2.
- Defaults, stream 1,1,0 then reset asserted with seq_in = 1 -> next edge crnt_state = 0, det_count = 0, seq_out = 0. A following 1,1,0,1 yields a detect.

Source files
------------

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial pattern detector with overlap control, input-valid
// qualifier and a saturating detection counter.
module moore_seq_detector_param #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8,
    parameter int                 ST_W    = $clog2(SEQ_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             seq_in,
    output logic             seq_out,
    output logic [CNT_W-1:0] det_count,
    output logic [ST_W-1:0]  crnt_state,
    output logic [ST_W-1:0]  nxt_state
);

    localparam int NUM_CODES = 2 ** ST_W;
    localparam logic [ST_W-1:0] DETECT = ST_W'(SEQ_LEN);

    // Pattern bit in arrival order: index 0 is the first bit received.
    function automatic bit pat_bit(input int i);
        return PATTERN[SEQ_LEN-1-i];
    endfunction

    // Length of the longest proper border (prefix that is also a suffix).
    function automatic int border_len();
        int  res;
        bit  found;
        bit  ok;
        res   = 0;
        found = 1'b0;
        for (int l = SEQ_LEN - 1; l > 0; l--) begin
            if (!found) begin
                ok = 1'b1;
                for (int i = 0; i < l; i++) begin
                    if (pat_bit(i) != pat_bit(SEQ_LEN - l + i)) ok = 1'b0;
                end
                if (ok) begin
                    res   = l;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Next state from state k_in on bit b: longest pattern prefix that is a
    // suffix of (matched prefix ++ b). DETECT first collapses to border or 0.
    function automatic int step_state(input int k_in, input bit b);
        int  k;
        int  res;
        int  p;
        bit  found;
        bit  ok;
        bit  sb;
        k     = (k_in == SEQ_LEN) ? (OVERLAP ? border_len() : 0) : k_in;
        res   = 0;
        found = 1'b0;
        for (int j = k + 1; j > 0; j--) begin
            if (!found) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++) begin
                    p  = k + 1 - j + i;
                    sb = (p < k) ? pat_bit(p) : b;
                    if (sb != pat_bit(i)) ok = 1'b0;
                end
                if (ok) begin
                    res   = j;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    logic [ST_W-1:0]  next_on0 [NUM_CODES];
    logic [ST_W-1:0]  next_on1 [NUM_CODES];
    logic [ST_W-1:0]  crnt_state_reg;
    logic [CNT_W-1:0] det_count_reg;

    // Transition table built at elaboration; unused encodings recover to 0.
    generate
        for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_tbl
            if (gi <= SEQ_LEN) begin : g_legal
                localparam logic [ST_W-1:0] N0 = ST_W'(step_state(gi, 1'b0));
                localparam logic [ST_W-1:0] N1 = ST_W'(step_state(gi, 1'b1));
                assign next_on0[gi] = N0;
                assign next_on1[gi] = N1;
            end else begin : g_illegal
                assign next_on0[gi] = '0;
                assign next_on1[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        nxt_state = crnt_state_reg;
        if (reset) begin
            nxt_state = '0;
        end else if (in_valid) begin
            nxt_state = seq_in ? next_on1[crnt_state_reg] : next_on0[crnt_state_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crnt_state_reg <= '0;
            det_count_reg  <= '0;
        end else begin
            crnt_state_reg <= nxt_state;
            if (in_valid && (nxt_state == DETECT) && (det_count_reg != {CNT_W{1'b1}})) begin
                det_count_reg <= det_count_reg + CNT_W'(1);
            end
        end
    end

    assign crnt_state = crnt_state_reg;
    assign det_count  = det_count_reg;
    assign seq_out    = (crnt_state_reg == DETECT);

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Directed bench for moore_seq_detector_param; four parameterisations share one
// stimulus bus and each scenario checks the instance it targets.
module tb_moore_seq_detector_param;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic seq_in = 1'b0;

    int vectors_applied = 0;
    int miscompares = 0;

    logic       def_out, novl_out, p010_out, sat_out;
    logic [7:0] def_cnt, novl_cnt, p010_cnt;
    logic [1:0] sat_cnt;
    logic [2:0] def_st, def_nx, novl_st, novl_nx;
    logic [1:0] p010_st, p010_nx, sat_st, sat_nx;

    always #5 clk = ~clk;

    moore_seq_detector_param u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .seq_in(seq_in),
        .seq_out(def_out), .det_count(def_cnt), .crnt_state(def_st), .nxt_state(def_nx)
    );

    moore_seq_detector_param #(.OVERLAP(1'b0)) u_novl (
        .clk(clk), .reset(reset), .in_valid(in_valid), .seq_in(seq_in),
        .seq_out(novl_out), .det_count(novl_cnt), .crnt_state(novl_st), .nxt_state(novl_nx)
    );

    moore_seq_detector_param #(.SEQ_LEN(3), .PATTERN(3'b010), .OVERLAP(1'b1)) u_010 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .seq_in(seq_in),
        .seq_out(p010_out), .det_count(p010_cnt), .crnt_state(p010_st), .nxt_state(p010_nx)
    );

    moore_seq_detector_param #(.SEQ_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .seq_in(seq_in),
        .seq_out(sat_out), .det_count(sat_cnt), .crnt_state(sat_st), .nxt_state(sat_nx)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Apply one cycle of input; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic v, input logic b);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = v;
        seq_in   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        seq_in   = 1'b1;
        #1;
        chk("rst_nxt_def", int'(def_nx), 0);
        @(posedge clk);
        #1;
    endtask

    int stream1 [9] = '{1, 1, 0, 1, 1, 0, 1, 0, 1};
    int def_st_exp [9] = '{1, 2, 3, 4, 2, 3, 4, 0, 1};
    int def_cnt_exp [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int novl_st_exp [9] = '{1, 2, 3, 4, 1, 0, 1, 0, 1};
    int s010 [5] = '{0, 1, 0, 1, 0};
    int p010_st_exp [5] = '{1, 2, 3, 2, 3};
    int p010_cnt_exp [5] = '{0, 0, 1, 1, 2};
    int sat_cnt_exp [7] = '{0, 1, 2, 3, 3, 3, 3};

    initial begin
        // Reset state
        do_reset();
        chk("rst_state", int'(def_st), 0);
        chk("rst_out", int'(def_out), 0);
        chk("rst_cnt", int'(def_cnt), 0);

        // Overlap and non-overlap on the same stream
        for (int i = 0; i < 9; i++) begin
            step(1'b1, stream1[i][0]);
            chk($sformatf("ovl_state_b%0d", i + 1), int'(def_st), def_st_exp[i]);
            chk($sformatf("ovl_out_b%0d", i + 1), int'(def_out), (def_st_exp[i] == 4) ? 1 : 0);
            chk($sformatf("ovl_cnt_b%0d", i + 1), int'(def_cnt), def_cnt_exp[i]);
            chk($sformatf("novl_state_b%0d", i + 1), int'(novl_st), novl_st_exp[i]);
            chk($sformatf("novl_out_b%0d", i + 1), int'(novl_out), (i == 3) ? 1 : 0);
        end
        chk("novl_cnt_end", int'(novl_cnt), 1);

        // in_valid gap holds the partial match
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0]);
            chk($sformatf("gap_state_%0d", i), int'(def_st), 3);
            chk($sformatf("gap_nxt_%0d", i), int'(def_nx), 3);
            chk($sformatf("gap_out_%0d", i), int'(def_out), 0);
        end
        step(1'b1, 1'b1);
        chk("gap_detect", int'(def_out), 1);
        chk("gap_cnt", int'(def_cnt), 1);
        step(1'b0, 1'b0);
        chk("gap_hold_out", int'(def_out), 1);
        chk("gap_hold_cnt", int'(def_cnt), 1);

        // Reset mid-match discards partial match and clears the counter
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("mid_pre_state", int'(def_st), 3);
        do_reset();
        chk("mid_rst_state", int'(def_st), 0);
        chk("mid_rst_cnt", int'(def_cnt), 0);
        chk("mid_rst_out", int'(def_out), 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("mid_after_out_b3", int'(def_out), 0);
        step(1'b1, 1'b1);
        chk("mid_after_out", int'(def_out), 1);
        chk("mid_after_cnt", int'(def_cnt), 1);

        // Pattern 010 with overlap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s010[i][0]);
            chk($sformatf("p010_state_b%0d", i + 1), int'(p010_st), p010_st_exp[i]);
            chk($sformatf("p010_out_b%0d", i + 1), int'(p010_out), (p010_st_exp[i] == 3) ? 1 : 0);
            chk($sformatf("p010_cnt_b%0d", i + 1), int'(p010_cnt), p010_cnt_exp[i]);
        end

        // Pattern 11, 2-bit counter saturation
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("sat_cnt_b%0d", i + 1), int'(sat_cnt), sat_cnt_exp[i]);
            chk($sformatf("sat_out_b%0d", i + 1), int'(sat_out), (i >= 1) ? 1 : 0);
            chk($sformatf("sat_state_b%0d", i + 1), int'(sat_st), (i >= 1) ? 2 : 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
